ioram_port_arbiter: RTL and testbench

Single-port arbiter for the 14-bit-addressed, 8-bit character IORAM. It shares the RAM between two requesters: the CPU memory stage (loads and stores to the I/O region) and the VGA character scanout reader. CPU has default priority. A run-length counter guarantees VGA service so the display never starves. It routes the registered 1-cycle RAM read data back to whichever requester issued the read.

---
 rtl/ioram_port_arbiter.sv | 111 +++++++++++
 tb/tb_ioram_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioram_port_arbiter.sv
// Single-port IORAM arbiter between the CPU memory stage and the VGA scanout reader.
// CPU has priority; a run-length counter forces one VGA grant after MAX_CPU_RUN CPU grants.
module ioram_port_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_CPU_RUN);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

    owner_t            rd_owner_reg, rd_owner_next;
    logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;
    logic              force_vga, gnt_cpu, gnt_vga;
    logic [DATA_W-1:0] cpu_rdata_reg, vga_rdata_reg;
    logic              cpu_rvalid_reg, vga_rvalid_reg;

    always_comb begin
        force_vga = vga_req & (run_cnt_reg == RUN_MAX);
        gnt_cpu   = cpu_req & ~force_vga;
        gnt_vga   = vga_req & ~gnt_cpu;
    end

    // State register: read owner for the data returning next cycle, plus CPU run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_reg <= OWN_NONE;
            run_cnt_reg  <= '0;
        end else begin
            rd_owner_reg <= rd_owner_next;
            run_cnt_reg  <= run_cnt_next;
        end
    end

    always_comb begin
        rd_owner_next = OWN_NONE;
        if (gnt_cpu && !cpu_we) begin
            rd_owner_next = OWN_CPU;
        end else if (gnt_vga) begin
            rd_owner_next = OWN_VGA;
        end

        run_cnt_next = '0;
        if (gnt_cpu && vga_req) begin
            run_cnt_next = (run_cnt_reg == RUN_MAX) ? run_cnt_reg : run_cnt_reg + 1'b1;
        end
    end

    // Write enable is additionally gated by rst so nothing lands in RAM while reset is held.
    always_comb begin
        cpu_stall = cpu_req & ~gnt_cpu;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (gnt_cpu) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we & ~rst;
            ram_wdata = cpu_wdata;
        end else if (gnt_vga) begin
            ram_addr  = vga_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_reg  <= '0;
            vga_rdata_reg  <= '0;
            cpu_rvalid_reg <= 1'b0;
            vga_rvalid_reg <= 1'b0;
        end else begin
            cpu_rvalid_reg <= (rd_owner_reg == OWN_CPU);
            vga_rvalid_reg <= (rd_owner_reg == OWN_VGA);
            if (rd_owner_reg == OWN_CPU) begin
                cpu_rdata_reg <= ram_rdata;
            end
            if (rd_owner_reg == OWN_VGA) begin
                vga_rdata_reg <= ram_rdata;
            end
        end
    end

    assign cpu_rdata  = cpu_rdata_reg;
    assign cpu_rvalid = cpu_rvalid_reg;
    assign vga_rdata  = vga_rdata_reg;
    assign vga_rvalid = vga_rvalid_reg;

endmodule

// File: tb/tb_ioram_port_arbiter.sv
// Bench for ioram_port_arbiter: behavioural IORAM, grant model feeding per-requester
// read scoreboards, and scenario tasks with inline checks.
module tb_ioram_port_arbiter;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int MAX_RUN = 4;
    localparam logic [1:0] G_NONE = 2'd0, G_CPU = 2'd1, G_VGA = 2'd2, G_WR = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    always #5 clk = ~clk;

    ioram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_RUN(MAX_RUN)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural IORAM with one-cycle registered read.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] cpu_q [$];
    logic [DATA_W-1:0] vga_q [$];
    logic [1:0]        g1 = G_NONE, g2 = G_NONE, m_g;
    int                m_run = 0;
    logic              m_fv, m_gc, m_gv;
    logic [DATA_W-1:0] m_d;

    // Model: predicts each cycle's grant, pushes expected read data, checks returns.
    always @(negedge clk) begin
        if (rst) begin
            cpu_q.delete();
            vga_q.delete();
            g1 = G_NONE;
            g2 = G_NONE;
            m_run = 0;
        end else begin
            n_checks++;
            if (cpu_rvalid !== (g2 == G_CPU))
                $display("FAIL sb_cpu_rvalid: got %b want %b", cpu_rvalid, (g2 == G_CPU));
            else n_pass++;
            if (cpu_rvalid === 1'b1) begin
                n_checks++;
                if (cpu_q.size() == 0) $display("FAIL sb_cpu_rdata: got %h want <no read outstanding>", cpu_rdata);
                else begin
                    m_d = cpu_q.pop_front();
                    if (cpu_rdata !== m_d) $display("FAIL sb_cpu_rdata: got %h want %h", cpu_rdata, m_d);
                    else n_pass++;
                end
            end
            n_checks++;
            if (vga_rvalid !== (g2 == G_VGA))
                $display("FAIL sb_vga_rvalid: got %b want %b", vga_rvalid, (g2 == G_VGA));
            else n_pass++;
            if (vga_rvalid === 1'b1) begin
                n_checks++;
                if (vga_q.size() == 0) $display("FAIL sb_vga_rdata: got %h want <no read outstanding>", vga_rdata);
                else begin
                    m_d = vga_q.pop_front();
                    if (vga_rdata !== m_d) $display("FAIL sb_vga_rdata: got %h want %h", vga_rdata, m_d);
                    else n_pass++;
                end
            end

            m_fv = vga_req && (m_run == MAX_RUN);
            m_gc = cpu_req && !m_fv;
            m_gv = vga_req && !m_gc;
            n_checks++;
            if (ram_we !== (m_gc && cpu_we))
                $display("FAIL sb_ram_we: got %b want %b", ram_we, (m_gc && cpu_we));
            else n_pass++;

            if (m_gc && !cpu_we) begin
                cpu_q.push_back(shadow[cpu_addr]);
                m_g = G_CPU;
            end else if (m_gc) begin
                shadow[cpu_addr] = cpu_wdata;
                m_g = G_WR;
            end else if (m_gv) begin
                vga_q.push_back(shadow[vga_addr]);
                m_g = G_VGA;
            end else begin
                m_g = G_NONE;
            end
            if (m_gc && vga_req) begin
                if (m_run < MAX_RUN) m_run++;
            end else begin
                m_run = 0;
            end
            g2 = g1;
            g1 = m_g;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        vga_req = 1'b0;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; vga_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'hAA;
        repeat (2) tick();
        #2;
        n_checks++;
        if (ram_we !== 1'b0) $display("FAIL rst_no_write: got %b want 0", ram_we); else n_pass++;
        n_checks++;
        if ({cpu_rvalid, vga_rvalid} !== 2'b00)
            $display("FAIL rst_rvalid: got %b%b want 00", cpu_rvalid, vga_rvalid); else n_pass++;
        n_checks++;
        if ({cpu_rdata, vga_rdata} !== 16'h0000)
            $display("FAIL rst_rdata: got %h %h want 00 00", cpu_rdata, vga_rdata); else n_pass++;
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        n_checks++;
        if ({ram_addr, ram_wdata, ram_we, cpu_stall} !== '0)
            $display("FAIL rst_idle_outputs: got addr %h wdata %h we %b stall %b want all 0",
                     ram_addr, ram_wdata, ram_we, cpu_stall);
        else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_cpu_write_read();
        cpu_write(14'h0010, 8'h41);
        #2;
        n_checks++;
        if ({ram_we, ram_addr, ram_wdata, cpu_stall} !== {1'b1, 14'h0010, 8'h41, 1'b0})
            $display("FAIL cpu_wr_drive: got we %b addr %h wdata %h stall %b want 1 0010 41 0",
                     ram_we, ram_addr, ram_wdata, cpu_stall);
        else n_pass++;
        tick();
        cpu_we = 1'b0;
        #2;
        n_checks++;
        if ({ram_we, ram_addr, cpu_stall} !== {1'b0, 14'h0010, 1'b0})
            $display("FAIL cpu_rd_drive: got we %b addr %h stall %b want 0 0010 0", ram_we, ram_addr, cpu_stall);
        else n_pass++;
        tick();
        cpu_req = 1'b0;
        #2;
        n_checks++;
        if ({ram_we, cpu_rvalid} !== 2'b00)
            $display("FAIL cpu_rd_early: got we %b rvalid %b want 0 0", ram_we, cpu_rvalid); else n_pass++;
        tick();
        #2;
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, cpu_stall} !== {1'b1, 8'h41, 1'b0})
            $display("FAIL cpu_rd_return: got rvalid %b data %h stall %b want 1 41 0", cpu_rvalid, cpu_rdata, cpu_stall);
        else n_pass++;
    endtask

    task automatic test_vga_stream();
        int idx = 0;
        logic [DATA_W-1:0] e;
        for (int i = 0; i < 4; i++) cpu_write(ADDR_W'(i), DATA_W'(8'h30 + i));
        idle();
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c < 4) begin
                vga_req = 1'b1; vga_addr = ADDR_W'(c);
            end else begin
                vga_req = 1'b0;
            end
            #2;
            if (vga_rvalid === 1'b1) begin
                e = DATA_W'(8'h30 + idx);
                n_checks++;
                if (idx > 3 || vga_rdata !== e)
                    $display("FAIL vga_stream_data: got %h want %h (beat %0d)", vga_rdata, e, idx);
                else n_pass++;
                idx++;
            end
        end
        n_checks++;
        if (idx != 4) $display("FAIL vga_stream_beats: got %0d want 4", idx); else n_pass++;
        n_checks++;
        if (vga_rdata !== 8'h33) $display("FAIL vga_hold: got %h want 33", vga_rdata); else n_pass++;
    endtask

    task automatic test_run_limit();
        int wait_now = 0;
        int wait_max = 0;
        logic exp_stall;
        idle();
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; vga_req = 1'b1; vga_addr = '0;
        for (int i = 0; i < 20; i++) begin
            #2;
            exp_stall = (i % 5 == 4);
            n_checks++;
            if (cpu_stall !== exp_stall)
                $display("FAIL run_stall: cycle %0d got %b want %b", i, cpu_stall, exp_stall);
            else n_pass++;
            n_checks++;
            if (ram_addr !== (exp_stall ? vga_addr : cpu_addr))
                $display("FAIL run_addr: cycle %0d got %h want %h", i, ram_addr,
                         (exp_stall ? vga_addr : cpu_addr));
            else n_pass++;
            if (cpu_stall === 1'b1) wait_now = 0;
            else wait_now++;
            if (wait_now > wait_max) wait_max = wait_now;
            tick();
            if (!exp_stall) cpu_addr = (cpu_addr + 14'd1) & 14'h3;
            else            vga_addr = (vga_addr + 14'd1) & 14'h3;
        end
        n_checks++;
        if (wait_max > MAX_RUN) $display("FAIL vga_wait: got %0d want <= %0d", wait_max, MAX_RUN); else n_pass++;
        repeat (3) idle();
    endtask

    task automatic test_same_addr();
        cpu_write(14'h0100, 8'h20);
        idle();
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'h58;
        vga_req = 1'b1; vga_addr = 14'h0100;
        #2;
        n_checks++;
        if ({ram_we, ram_wdata, cpu_stall} !== {1'b1, 8'h58, 1'b0})
            $display("FAIL same_cpu_first: got we %b wdata %h stall %b want 1 58 0", ram_we, ram_wdata, cpu_stall);
        else n_pass++;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        #2;
        n_checks++;
        if ({ram_we, ram_addr} !== {1'b0, 14'h0100})
            $display("FAIL same_vga_next: got we %b addr %h want 0 0100", ram_we, ram_addr); else n_pass++;
        tick();
        vga_req = 1'b0;
        tick();
        #2;
        n_checks++;
        if ({vga_rvalid, vga_rdata} !== {1'b1, 8'h58})
            $display("FAIL same_vga_data: got rvalid %b data %h want 1 58", vga_rvalid, vga_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle();
        tick();
        vga_req = 1'b1; vga_addr = 14'h0002;
        tick();
        vga_req = 1'b0; rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst = 1'b0;
            #2;
            n_checks++;
            if (vga_rvalid !== 1'b0) $display("FAIL mid_rst_rvalid: cycle %0d got %b want 0", i, vga_rvalid);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (vga_rdata !== 8'h00) $display("FAIL mid_rst_rdata: got %h want 00", vga_rdata); else n_pass++;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0001; vga_req = 1'b1; vga_addr = 14'h0003;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_checks++;
            if (cpu_stall !== (i == 4))
                $display("FAIL mid_rst_prio: cycle %0d got stall %b want %b", i, cpu_stall, (i == 4));
            else n_pass++;
            tick();
        end
        repeat (3) idle();
    endtask

    task automatic test_writes_only();
        for (int i = 0; i < 8; i++) begin
            cpu_write(ADDR_W'(14'h0200 + i), DATA_W'(i));
            #2;
            n_checks++;
            if ({cpu_rvalid, vga_rvalid, cpu_stall, ram_we} !== 4'b0001)
                $display("FAIL wr_only: cycle %0d got rv %b%b stall %b we %b want 00 0 1",
                         i, cpu_rvalid, vga_rvalid, cpu_stall, ram_we);
            else n_pass++;
        end
        repeat (3) idle();
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_vga_stream();
        test_run_limit();
        test_same_addr();
        test_reset_mid();
        test_writes_only();
        n_checks++;
        if (cpu_q.size() != 0 || vga_q.size() != 0)
            $display("FAIL sb_drain: got cpu %0d vga %0d outstanding want 0 0", cpu_q.size(), vga_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
